// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8-N-1 UART receiver with centre sampling,
// valid/ready delivery, framing-error and overrun pulses.
// Ports: clk_in, reset (async, active-high), rx_in (raw line),
//   data_out/data_valid/data_ready (byte handshake),
//   frame_err, overrun (1-cycle pulses), busy (not IDLE).
// Option: define UART_RX_PARITY_EN for an even-parity bit
//   between the data bits and the stop bit.
module uart_rx_ctrl #(
   parameter int BIT_DIV = 434,
   parameter int CNT_W   = 9
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, BREAK
   } state_t;

   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BIT_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_DIV - 1);

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
   logic             par_ok_q, par_ok_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      // a handshake frees the output register on this edge
      valid_d = valid_q & ~data_ready;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_d = par_ok_q;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_END) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shreg_d = {rx_s_q, shreg_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (cnt_q == BIT_END) begin
               cnt_d    = '0;
               par_ok_d = ~^{shreg_q, rx_s_q};
               state_d  = STOP;
            end
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end else begin
                  // back to IDLE at stop centre for back-to-back frames
                  state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (!par_ok_q) begin
                     ferr_d = 1'b1;
                  end else
`endif
                  if (!valid_q || data_ready) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_ok_q  <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_in;
         rx_s_q    <= rx_meta_q;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
         busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_ok_q  <= par_ok_d;
`endif
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl
// with BIT_DIV=8 and a byte scoreboard.
module tb_uart_rx_ctrl;

   localparam int BD = 8;

   logic       clk_in = 1'b0;
   logic       reset;
   logic       rx_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int pop_cnt = 0;
   logic ferr_prev = 1'b0;
   logic ovr_prev = 1'b0;
   logic [7:0] exp_q[$];

   uart_rx_ctrl #(.BIT_DIV(BD), .CNT_W(4)) dut (
      .clk_in(clk_in),
      .reset(reset),
      .rx_in(rx_in),
      .data_out(data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .frame_err(frame_err),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx_in = 1'b0;
      step(BD);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         step(BD);
      end
`ifdef UART_RX_PARITY_EN
      rx_in = ^b;
      step(BD);
`endif
      rx_in = stop_bit;
      step(BD);
      rx_in = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_par(input logic [7:0] b, input logic par_bit);
      rx_in = 1'b0;
      step(BD);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         step(BD);
      end
      rx_in = par_bit;
      step(BD);
      rx_in = 1'b1;
      step(BD);
   endtask
`endif

   task automatic wait_valid(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (data_valid) break;
         step(1);
      end
      chk(tag, 32'(data_valid), 32'd1);
   endtask

   // monitor: samples on the falling edge, away from DUT updates
   always @(negedge clk_in) begin
      if (!reset) begin
         if (data_valid && data_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'(data_out), 32'hFFFF);
            end else begin
               chk("sb_byte", 32'(data_out), 32'(exp_q.pop_front()));
            end
         end
         if (frame_err) begin
            ferr_cnt++;
            if (ferr_prev) chk("ferr_width", 32'd2, 32'd1);
         end
         if (overrun) begin
            ovr_cnt++;
            if (ovr_prev) chk("ovr_width", 32'd2, 32'd1);
         end
         if (frame_err || overrun)
            chk("ferr_ovr_excl", 32'(frame_err & overrun), 32'd0);
      end
      ferr_prev = frame_err;
      ovr_prev  = overrun;
   end

   initial begin
      int f0, o0, p0;
      reset = 1'b1;
      rx_in = 1'b1;
      data_ready = 1'b0;
      step(3);
      chk("rst_data_out", 32'(data_out), 32'h00);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step(4);

      // 1: single byte, consumer not ready
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      wait_valid("t1_valid", 20);
      chk("t1_data", 32'(data_out), 32'hA5);
      for (int i = 0; i < 3; i++) begin
         step(7);
         chk("t1_hold_valid", 32'(data_valid), 32'd1);
         chk("t1_hold_data", 32'(data_out), 32'hA5);
      end
      data_ready = 1'b1;
      step(1);
      chk("t1_clear", 32'(data_valid), 32'd0);
      data_ready = 1'b0;
      chk("t1_popped", 32'(exp_q.size()), 32'd0);

      // 2: short glitch on the line
      f0 = ferr_cnt;
      p0 = pop_cnt;
      rx_in = 1'b0;
      step(3);
      rx_in = 1'b1;
      step(2);
      chk("t2_busy_hi", 32'(busy), 32'd1);
      step(20);
      chk("t2_busy_lo", 32'(busy), 32'd0);
      chk("t2_valid", 32'(data_valid), 32'd0);
      chk("t2_ferr", 32'(ferr_cnt - f0), 32'd0);

      // 3: bad stop bit then held low (break)
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      rx_in = 1'b0;
      step(20);
      chk("t3_ferr", 32'(ferr_cnt - f0), 32'd1);
      chk("t3_busy_brk", 32'(busy), 32'd1);
      chk("t3_valid", 32'(data_valid), 32'd0);
      rx_in = 1'b1;
      step(5);
      chk("t3_busy_lo", 32'(busy), 32'd0);
      chk("t3_no_pop", 32'(pop_cnt - p0), 32'd0);
      step(10);

      // 4: back-to-back with consumer stalled
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      step(3);
      chk("t4_ovr", 32'(ovr_cnt - o0), 32'd1);
      chk("t4_ferr", 32'(ferr_cnt - f0), 32'd0);
      chk("t4_data", 32'(data_out), 32'h11);
      chk("t4_valid", 32'(data_valid), 32'd1);
      data_ready = 1'b1;
      step(1);
      data_ready = 1'b0;
      chk("t4_popped", 32'(exp_q.size()), 32'd0);
      step(10);

      // 5: back-to-back with consumer always ready
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      p0 = pop_cnt;
      data_ready = 1'b1;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      step(5);
      data_ready = 1'b0;
      chk("t5_pops", 32'(pop_cnt - p0), 32'd2);
      chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
      chk("t5_errs", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
      step(10);

      // 6: reset in the middle of 8'hFF, then 8'h5A
      rx_in = 1'b0;
      step(BD);
      rx_in = 1'b1;
      step(4 * BD + BD / 2);
      chk("t6_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      step(2);
      chk("t6_rst_data", 32'(data_out), 32'h00);
      chk("t6_rst_valid", 32'(data_valid), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step(6 * BD);
      chk("t6_no_partial", 32'(data_valid), 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_valid("t6_valid", 20);
      chk("t6_data", 32'(data_out), 32'h5A);
      data_ready = 1'b1;
      step(1);
      data_ready = 1'b0;
      step(10);

`ifdef UART_RX_PARITY_EN
      f0 = ferr_cnt;
      p0 = pop_cnt;
      send_par(8'h07, 1'b0);
      step(3);
      chk("p_bad_ferr", 32'(ferr_cnt - f0), 32'd1);
      chk("p_bad_valid", 32'(data_valid), 32'd0);
      exp_q.push_back(8'h07);
      send_par(8'h07, 1'b1);
      wait_valid("p_good_valid", 20);
      chk("p_good_data", 32'(data_out), 32'h07);
      data_ready = 1'b1;
      step(1);
      data_ready = 1'b0;
      chk("p_pops", 32'(pop_cnt - p0), 32'd1);
      step(5);
`endif

      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
